// File: rtl/timecounter.sv
// Time-of-day counter (hh:mi:ss, packed BCD) with a CLK_DIV-cycle prescaler,
// run/setting modes, per-field inc/dec editing and a midnight rollover pulse.
`timescale 1ns/1ps

module timecounter #(
    parameter int CLK_DIV = 50000000    // clk cycles per second; must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       inc,
    input  logic       dec,
    input  logic [1:0] sel,
    output logic [7:0] ss,
    output logic [7:0] mi,
    output logic [7:0] hh,
    output logic       sec_tick,
    output logic       dayroll
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_SS   = 2'b01,
        SEL_MI   = 2'b10,
        SEL_HH   = 2'b11
    } field_e;

    localparam int            PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc, presc_nxt;
    logic [7:0]    ss_nxt, mi_nxt, hh_nxt;
    logic          tick_nxt, roll_nxt;
    field_e        field;

    // Digit-wise BCD steps with wrap at max; never produce codes A..F.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        else if (v[3:0] == 4'h0)
            return {v[7:4] - 4'h1, 4'h9};
        else
            return {v[7:4], v[3:0] - 4'h1};
    endfunction

    assign field = field_e'(sel);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        presc_nxt = presc;
        ss_nxt    = ss;
        mi_nxt    = mi;
        hh_nxt    = hh;
        tick_nxt  = 1'b0;
        roll_nxt  = 1'b0;

        if (freeze) begin
            presc_nxt = '0;
            // inc together with dec cancels out; edits never carry between fields.
            if (inc ^ dec) begin
                case (field)
                    SEL_SS:  ss_nxt = inc ? bcd_inc(ss, 8'h59) : bcd_dec(ss, 8'h59);
                    SEL_MI:  mi_nxt = inc ? bcd_inc(mi, 8'h59) : bcd_dec(mi, 8'h59);
                    SEL_HH:  hh_nxt = inc ? bcd_inc(hh, 8'h23) : bcd_dec(hh, 8'h23);
                    default: ;
                endcase
            end
        end else if (presc == PRE_LAST) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            ss_nxt    = bcd_inc(ss, 8'h59);
            if (ss == 8'h59) begin
                mi_nxt = bcd_inc(mi, 8'h59);
                if (mi == 8'h59) begin
                    hh_nxt   = bcd_inc(hh, 8'h23);
                    roll_nxt = (hh == 8'h23);
                end
            end
        end else begin
            presc_nxt = presc + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            ss       <= 8'h00;
            mi       <= 8'h00;
            hh       <= 8'h00;
            sec_tick <= 1'b0;
            dayroll  <= 1'b0;
        end else begin
            presc    <= presc_nxt;
            ss       <= ss_nxt;
            mi       <= mi_nxt;
            hh       <= hh_nxt;
            sec_tick <= tick_nxt;
            dayroll  <= roll_nxt;
        end
    end

endmodule

// File: tb/tb_timecounter.sv
// Self-checking bench for timecounter: directed scenarios plus randomized mode/edit
// traffic, compared every cycle against a seconds-of-day reference model.
`timescale 1ns/1ps

module tb_timecounter;

    localparam int CLK_DIV = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       freeze = 1'b0;
    logic       inc    = 1'b0;
    logic       dec    = 1'b0;
    logic [1:0] sel    = 2'b00;
    logic [7:0] ss, mi, hh;
    logic       sec_tick, dayroll;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: elapsed run cycles since the last second, and seconds since midnight.
    int m_cnt  = 0;
    int m_secs = 0;
    bit m_tick = 1'b0;
    bit m_roll = 1'b0;

    timecounter #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .freeze   (freeze),
        .inc      (inc),
        .dec      (dec),
        .sel      (sel),
        .ss       (ss),
        .mi       (mi),
        .hh       (hh),
        .sec_tick (sec_tick),
        .dayroll  (dayroll)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic logic is_bcd(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int h, m, s, d;
        if (!rst) begin
            m_cnt = 0; m_secs = 0; m_tick = 1'b0; m_roll = 1'b0;
        end else if (freeze) begin
            m_cnt = 0; m_tick = 1'b0; m_roll = 1'b0;
            if (inc != dec && sel != 2'b00) begin
                d = inc ? 1 : -1;
                h = m_secs / 3600;
                m = (m_secs / 60) % 60;
                s = m_secs % 60;
                case (sel)
                    2'b01:   s = (s + d + 60) % 60;
                    2'b10:   m = (m + d + 60) % 60;
                    default: h = (h + d + 24) % 24;
                endcase
                m_secs = h * 3600 + m * 60 + s;
            end
        end else begin
            m_cnt++;
            m_roll = 1'b0;
            m_tick = (m_cnt == CLK_DIV);
            if (m_tick) begin
                m_cnt  = 0;
                m_secs = (m_secs + 1) % 86400;
                m_roll = (m_secs == 0);
            end
        end
    endtask

    task automatic compare_all();
        check("ss",       32'(ss),       32'(to_bcd(m_secs % 60)));
        check("mi",       32'(mi),       32'(to_bcd((m_secs / 60) % 60)));
        check("hh",       32'(hh),       32'(to_bcd(m_secs / 3600)));
        check("sec_tick", 32'(sec_tick), 32'(m_tick));
        check("dayroll",  32'(dayroll),  32'(m_roll));
    endtask

    // One clock: drive at negedge, update the model at posedge, sample 1 ns later.
    task automatic cycle(input logic r, input logic f, input logic i, input logic d,
                         input logic [1:0] s, input bit glitch = 1'b0);
        @(negedge clk);
        rst = r; freeze = f; inc = i; dec = d; sel = s;
        if (glitch) begin
            #1 rst = 1'b0;
            #1 rst = 1'b1;
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic edit(input logic i, input logic d, input logic [1:0] s);
        cycle(1'b1, 1'b1, i, d, s);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b11);
    endtask

    task automatic first_tick_after(input string tag);
        int k;
        k = 0;
        for (int j = 1; j <= 3 * CLK_DIV; j++) begin
            run(1);
            if (sec_tick) begin
                k = j;
                break;
            end
        end
        check(tag, 32'(k), 32'(CLK_DIV));
    endtask

    int rolls;

    initial begin
        // Reset state and first second.
        do_reset();
        for (int j = 1; j <= CLK_DIV; j++) run(1);
        check("first_tick_time", {8'h0, hh, mi, ss}, 32'h0000_0001);

        // Set 23:59:58 and run through midnight.
        edit(1'b0, 1'b1, 2'b11);
        edit(1'b0, 1'b1, 2'b10);
        edit(1'b0, 1'b1, 2'b01);
        edit(1'b0, 1'b1, 2'b01);
        edit(1'b0, 1'b1, 2'b01);
        check("set_235958", {8'h0, hh, mi, ss}, 32'h0023_5958);
        run(2 * CLK_DIV);
        check("midnight_time", {8'h0, hh, mi, ss}, 32'h0000_0000);
        run(1);
        check("dayroll_one_cycle", 32'(dayroll), 32'h0);

        // Hours decrement wrap, seconds increment wrap, inc+dec cancel, sel=00 and run-mode ignore.
        edit(1'b0, 1'b1, 2'b11);
        check("hh_dec_wrap", {8'h0, hh, mi, ss}, 32'h0023_0000);
        for (int j = 0; j < 59; j++) edit(1'b1, 1'b0, 2'b01);
        edit(1'b1, 1'b0, 2'b01);
        check("ss_inc_wrap", {8'h0, hh, mi, ss}, 32'h0023_0000);
        edit(1'b1, 1'b1, 2'b01);
        edit(1'b1, 1'b0, 2'b00);
        edit(1'b0, 1'b1, 2'b00);
        edit(1'b0, 1'b1, 2'b10);
        edit(1'b1, 1'b1, 2'b10);
        check("mi_dec_wrap", {8'h0, hh, mi, ss}, 32'h0023_5900);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b11);

        // Reset in the dayroll cycle, then prescaler restart.
        do_reset();
        edit(1'b0, 1'b1, 2'b11);
        edit(1'b0, 1'b1, 2'b10);
        edit(1'b0, 1'b1, 2'b01);
        run(CLK_DIV);
        check("dayroll_before_rst", 32'(dayroll), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        first_tick_after("tick_after_rst");

        // Freeze rising on the wrap cycle wins; then restart latency; async glitch ignored.
        run(CLK_DIV - 1);
        edit(1'b0, 1'b0, 2'b00);
        check("freeze_wins_tick", 32'(sec_tick), 32'h0);
        first_tick_after("tick_after_freeze");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1);

        // Randomized segments of run/setting traffic with rare resets.
        for (int seg = 0; seg < 400; seg++) begin
            logic f;
            int   len;
            f   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 3 * CLK_DIV);
            for (int j = 0; j < len; j++) begin
                cycle(logic'($urandom_range(0, 149) != 0), f,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)));
            end
        end

        // Free run through an hour boundary and midnight from 23:00:00.
        do_reset();
        edit(1'b0, 1'b1, 2'b11);
        rolls = 0;
        for (int j = 0; j < 3600 * CLK_DIV; j++) begin
            run(1);
            if (dayroll) rolls++;
            check("bcd_valid", 32'({is_bcd(hh), is_bcd(mi), is_bcd(ss)}), 32'h7);
        end
        check("free_run_rolls", 32'(rolls), 32'h1);
        check("free_run_final", {8'h0, hh, mi, ss}, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timecounter.md
TIMECOUNTER -- requirements
Module: timecounter

Interface
REQ-001 Parameter CLK_DIV, default 50000000, is the number of clk cycles per second tick and SHALL be at least 2.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 freeze  input  1  1 = setting mode (counting halted, inc/dec active); 0 = run mode.
REQ-005 inc  input  1  one-cycle request to increment the selected field (setting mode only).
REQ-006 dec  input  1  one-cycle request to decrement the selected field (setting mode only).
REQ-007 sel  input  2  field select: 01 = seconds, 10 = minutes, 11 = hours, 00 = none.
REQ-008 ss  output  8  seconds, packed BCD, 8'h00..8'h59.
REQ-009 mi  output  8  minutes, packed BCD, 8'h00..8'h59.
REQ-010 hh  output  8  hours, packed BCD, 8'h00..8'h23.
REQ-011 sec_tick  output  1  one-cycle pulse each time the prescaler completes one second.
REQ-012 dayroll  output  1  one-cycle pulse on midnight rollover; it drives the downstream date counter's dayroll input directly.

Function
REQ-013 The prescaler SHALL count 0..CLK_DIV-1 while freeze=0, and SHALL assert sec_tick in the cycle in which it wraps to 0.
REQ-014 While freeze=1, the prescaler SHALL be held at 0 and sec_tick SHALL stay 0.
REQ-015 After freeze falls, the first sec_tick SHALL occur exactly CLK_DIV cycles later.
REQ-016 In run mode, each sec_tick SHALL advance the time by one second in BCD.
- ss: 59 -> 00 carries into mi.
- mi: 59 -> 00 carries into hh.
- hh: 23 -> 00.
REQ-017 On the sec_tick that moves 23:59:59 to 00:00:00, dayroll SHALL be registered high for exactly that one following cycle, coincident with outputs showing 00:00:00.
REQ-018 dayroll SHALL never assert in setting mode or as a result of inc/dec.
REQ-019 Every digit update SHALL be a valid BCD step: low nibble 9 -> 0 with carry into the high nibble. Binary overflow codes (x'A..x'F) SHALL never appear on ss, mi or hh.
REQ-020 In setting mode, inc on the selected field SHALL add 1 with wrap (ss/mi: 59 -> 00, hh: 23 -> 00), and SHALL not carry into any other field.
REQ-021 In setting mode, dec on the selected field SHALL subtract 1 with wrap (ss/mi: 00 -> 59, hh: 00 -> 23), and SHALL not borrow from any other field.
REQ-022 If inc and dec are both 1 in the same cycle, the time SHALL remain unchanged.
REQ-023 With sel=00, inc and dec SHALL be ignored.
REQ-024 In run mode, inc and dec SHALL be ignored.
REQ-025 Each cycle with inc or dec high SHALL produce one step. Any edge detection or debouncing is done upstream.
REQ-026 Edit latency: a field change SHALL be visible on the outputs one cycle after the inc/dec sample.
REQ-027 If freeze rises in the same cycle as a pending wrap, freeze SHALL win: no tick and no dayroll.

Reset
REQ-028 When rst=0 at a rising edge of clk, the block SHALL load:
- ss = mi = hh = 8'h00
- prescaler = 0
- sec_tick = 0, dayroll = 0
REQ-029 Reset SHALL override freeze, inc, dec and any in-progress tick, including a rollover cycle.
REQ-030 Reset SHALL take effect only on a clock edge; an asynchronous rst glitch SHALL have no effect.

Verification
REQ-031 Run CLK_DIV=4, reset, freeze=0 for 4 cycles -> sec_tick on cycle 4, time 00:00:01.
REQ-032 Set 23:59:58 in setting mode, release freeze, wait 8 cycles (CLK_DIV=4) -> 23:59:59, then 00:00:00 with dayroll high exactly 1 cycle.
REQ-033 freeze=1, sel=11, hh=00, one dec pulse -> hh=23, mi/ss unchanged, dayroll=0.
REQ-034 freeze=1, sel=01, ss=59, inc -> ss=00 with mi unchanged; inc and dec together -> no change.
REQ-035 Drive rst=0 in the dayroll cycle at 00:00:00 -> next cycle: all outputs zero, dayroll=0, and the prescaler restarts (first tick CLK_DIV cycles after rst=1).
REQ-036 Free-run 86400 ticks from 00:00:00 -> exactly one dayroll pulse, final time 00:00:00, and no non-BCD value ever observed on ss, mi or hh.
